write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 32: number of buffered write entries (power of two, >=2).
REQ-002 Parameter ADDRESS_WIDTH, default 32: address width of both ports.
REQ-003 Parameter STALL_READ, default 1: 1 = reads wait for buffer drain; 0 = reads bypass queued writes.
REQ-004 i_clock  in  1  single clock; all logic on rising edge.
REQ-005 i_reset  in  1  asynchronous active-low reset (0 = reset).
REQ-006 o_empty  out  1  buffer holds no entries and no buffered write is on the bus.
REQ-007 o_full  out  1  buffer holds DEPTH entries.
REQ-008 i_cached  in  1  1 = write may be buffered; 0 = write must be ordered and passed through.
REQ-009 o_bus_rw, o_bus_request, o_bus_address[AW], o_bus_wdata[32], o_bus_wmask[4]  out  downstream bus command.
REQ-010 i_bus_ready  in  1, i_bus_rdata  in  32  downstream completion and read data.
REQ-011 i_rw (1 = write), i_request, i_address[AW], i_wdata[32], i_wmask[4]  in  upstream request.
REQ-012 o_ready  out  1, o_rdata  out  32  upstream completion and read data.

Function
REQ-013 Upstream handshake: requester holds i_request and operands until o_ready; o_ready SHALL be high exactly one cycle per request.
REQ-014 After an o_ready pulse, i_request SHALL be ignored until sampled low for at least one cycle (held request is never accepted twice).
REQ-015 Cached write, buffer not full: push {address, wdata, wmask}; o_ready the cycle after i_request is first sampled.
REQ-016 Cached write, buffer full: stall (no o_ready) until an entry drains, then push and ack.
REQ-017 Uncached write: stall until buffer empty and bus idle, issue directly to bus, o_ready the cycle after i_bus_ready.
REQ-018 Read with STALL_READ=1: stall until buffer empty and bus idle, issue read, capture i_bus_rdata into o_rdata on i_bus_ready, o_ready next cycle.
REQ-019 Read with STALL_READ=0: issue as soon as bus idle, taking priority over the next drain entry; an in-flight drain completes first.
REQ-020 o_rdata SHALL hold the last captured read value until the next read completes.
REQ-021 Drain: whenever bus idle and buffer non-empty (and no higher-priority access), issue head entry as write (o_bus_rw=1) in FIFO order; pop on i_bus_ready.
REQ-022 Bus protocol: o_bus_request and command fields held stable until i_bus_ready; request deasserted the cycle after ready; new request only once i_bus_ready sampled low.
REQ-023 Bus command fields SHALL be exact copies of the buffered or passed-through operands; wmask forwarded unmodified.
REQ-024 Simultaneous push and pop in one cycle SHALL be supported; count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; o_full at count==DEPTH, no push beyond.
REQ-026 Control FSM states: IDLE, WAIT_DRAIN, BUS_ACCESS, ACK, WAIT_RELEASE; drain engine separate: D_IDLE, D_BUSY, D_RELEASE.

Reset
REQ-027 While i_reset=0: buffer flushed (count 0, pointers 0), FSMs to IDLE/D_IDLE, pending entries discarded.
REQ-028 Reset outputs: o_empty=1, o_full=0, o_ready=0, o_rdata=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, o_bus_wmask=0.
REQ-029 Reset asserted mid-transaction SHALL drop o_bus_request immediately; no completion is reported afterwards.

Verification
REQ-030 Three cached writes cafe_0001/b00b_1111/1010, cafe_0002/b00b_2222/0101, cafe_0003/b00b_3333/1111 -> each o_ready one cycle after request; bus sees them in order with identical data/masks.
REQ-031 Uncached write cafe_0004/b00b_4444 after those -> no o_ready until all three drained; then single bus write, o_ready after its i_bus_ready.
REQ-032 Read cafe_0003 with bus returning {addr[15:0],addr[31:16]} -> o_rdata=0003cafe with o_ready, one bus read, o_bus_rw=0.
REQ-033 Four cached writes cafe_0005..0008 then read cafe_0005 (STALL_READ=1) -> read issued only after fourth write drains; o_rdata=0005cafe.
REQ-034 Fill DEPTH cached writes with bus ready withheld -> o_full=1, next write stalls; release bus -> write accepted after first pop.
REQ-035 Cached write cafe_0009, reset asserted two cycles later -> o_bus_request=0, o_empty=1, o_ready never pulses after reset.

Source files
------------

// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between an upstream requester and a downstream bus.
//   Clock/reset : i_clock (rising edge), i_reset (async, active-low)
//   Upstream    : i_rw, i_request, i_address, i_wdata, i_wmask, i_cached -> o_ready, o_rdata
//   Downstream  : o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_bus_wmask <- i_bus_ready, i_bus_rdata
//   Status      : o_empty, o_full
module write_buffer #(
  parameter int DEPTH         = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STALL_READ    = 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  output logic                     o_empty,
  output logic                     o_full,
  input  logic                     i_cached,
  output logic                     o_bus_rw,
  output logic                     o_bus_request,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [31:0]              o_bus_wdata,
  output logic [3:0]               o_bus_wmask,
  input  logic                     i_bus_ready,
  input  logic [31:0]              i_bus_rdata,
  input  logic                     i_rw,
  input  logic                     i_request,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_wmask,
  output logic                     o_ready,
  output logic [31:0]              o_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDRESS_WIDTH + 36;
  typedef enum logic [2:0] {IDLE, WAIT_DRAIN, BUS_ACCESS, ACK, WAIT_RELEASE} ctl_t;
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_RELEASE} drn_t;
  ctl_t ctl_q, ctl_d;
  drn_t drn_q, drn_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic bus_req_q, bus_req_d, bus_rw_q, bus_rw_d;
  logic [ADDRESS_WIDTH-1:0] bus_addr_q, bus_addr_d, head_addr;
  logic [31:0] bus_wdata_q, bus_wdata_d, head_wdata, rdata_q, rdata_d;
  logic [3:0] bus_wmask_q, bus_wmask_d, head_wmask;
  logic full, bus_idle, cached_wr, can_go, arm, fire, push, launch, drn_launch, pop;
  assign {head_addr, head_wdata, head_wmask} = mem_q[rd_ptr_q];
  assign full      = count_q == CW'(DEPTH);
  // The bus is free only once the previous owner has seen ready fall.
  assign bus_idle  = drn_q == D_IDLE && !bus_req_q && !i_bus_ready;
  assign cached_wr = i_rw && i_cached;
  // Uncached writes and stalling reads need an empty buffer; bypassing reads only a free bus.
  assign can_go    = cached_wr ? !full
                   : bus_idle && (count_q == '0 || (!i_rw && STALL_READ == 0));
  assign arm       = (ctl_q == IDLE && i_request) || ctl_q == WAIT_DRAIN;
  assign fire      = arm && can_go;
  assign push      = fire && cached_wr;
  assign launch    = fire && !cached_wr;
  // Upstream accesses win the bus over the next drain entry.
  assign drn_launch = bus_idle && count_q != '0 && !launch;
  assign pop       = drn_q == D_BUSY && i_bus_ready;
  always_comb begin
    ctl_d = ctl_q;
    case (ctl_q)
      IDLE, WAIT_DRAIN: ctl_d = fire ? (push ? ACK : BUS_ACCESS) : arm ? WAIT_DRAIN : IDLE;
      BUS_ACCESS:       ctl_d = i_bus_ready ? ACK : BUS_ACCESS;
      ACK:              ctl_d = WAIT_RELEASE;
      WAIT_RELEASE:     ctl_d = i_request ? WAIT_RELEASE : IDLE;
      default:          ctl_d = IDLE;
    endcase
  end
  always_comb begin
    drn_d = drn_q;
    case (drn_q)
      D_IDLE:    drn_d = drn_launch ? D_BUSY : D_IDLE;
      D_BUSY:    drn_d = i_bus_ready ? D_RELEASE : D_BUSY;
      D_RELEASE: drn_d = i_bus_ready ? D_RELEASE : D_IDLE;
      default:   drn_d = D_IDLE;
    endcase
  end
  always_comb begin
    bus_req_d   = (launch || drn_launch) ? 1'b1 : (bus_req_q && !i_bus_ready);
    bus_rw_d    = launch ? i_rw      : drn_launch ? 1'b1       : bus_rw_q;
    bus_addr_d  = launch ? i_address : drn_launch ? head_addr  : bus_addr_q;
    bus_wdata_d = launch ? i_wdata   : drn_launch ? head_wdata : bus_wdata_q;
    bus_wmask_d = launch ? i_wmask   : drn_launch ? head_wmask : bus_wmask_q;
    rdata_d     = (ctl_q == BUS_ACCESS && i_bus_ready && !bus_rw_q) ? i_bus_rdata : rdata_q;
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctl_q       <= IDLE;
      drn_q       <= D_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      rdata_q     <= '0;
    end else begin
      ctl_q       <= ctl_d;
      drn_q       <= drn_d;
      wr_ptr_q    <= wr_ptr_q + PW'(push);
      rd_ptr_q    <= rd_ptr_q + PW'(pop);
      count_q     <= count_q + CW'(push) - CW'(pop);
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      rdata_q     <= rdata_d;
    end
  end
  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= {i_address, i_wdata, i_wmask};
  end
  assign o_empty       = count_q == '0;
  assign o_full        = full;
  assign o_ready       = ctl_q == ACK;
  assign o_rdata       = rdata_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_bus_wmask   = bus_wmask_q;
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed self-checking bench for write_buffer.
module tb_write_buffer;
  logic clk = 0, rst_n = 0;
  logic rw = 0, req = 0, cached = 0, bus_ready = 0, bus_hold = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic [3:0] wmask = 0;
  logic o_empty, o_full, o_bus_rw, o_bus_request, o_ready;
  logic [31:0] o_bus_address, o_bus_wdata, o_rdata;
  logic [3:0] o_bus_wmask;
  logic [31:0] log_addr [64], log_wdata [64];
  logic [3:0] log_mask [64];
  logic log_rw [64];
  int nlog = 0, total = 0, bad = 0, lat, base, cnt;
  always #5 clk = ~clk;
  write_buffer #(.DEPTH(4), .ADDRESS_WIDTH(32), .STALL_READ(1)) dut (
    .i_clock(clk), .i_reset(rst_n), .o_empty(o_empty), .o_full(o_full), .i_cached(cached),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
    .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask), .i_bus_ready(bus_ready),
    .i_bus_rdata(bus_rdata), .i_rw(rw), .i_request(req), .i_address(addr), .i_wdata(wdata),
    .i_wmask(wmask), .o_ready(o_ready), .o_rdata(o_rdata));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Bus responder: one-cycle ready pulse per request, logging each completed command.
  initial forever begin
    @(posedge clk); #1;
    if (bus_ready) bus_ready = 0;
    else if (o_bus_request && !bus_hold && rst_n) begin
      bus_ready = 1;
      bus_rdata = {o_bus_address[15:0], o_bus_address[31:16]};
      log_addr[nlog] = o_bus_address;
      log_wdata[nlog] = o_bus_wdata;
      log_mask[nlog] = o_bus_wmask;
      log_rw[nlog] = o_bus_rw;
      nlog++;
    end
  end
  task automatic host(input logic w, input logic c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, output int l);
    @(negedge clk);
    rw = w; cached = c; addr = a; wdata = d; wmask = m; req = 1; l = 0;
    do begin @(negedge clk); l++; end while (!o_ready && l < 300);
    if (!o_ready) chk("ack_timeout", 0, 1);
    req = 0;
    @(negedge clk);
    chk("ready_pulse", o_ready, 0);
  endtask
  task automatic wait_empty();
    int n = 0;
    while (!(o_empty && !o_bus_request && !bus_ready) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("empty_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_log(input int i, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    chk("log_rw", log_rw[i], r);
    chk("log_addr", log_addr[i], a);
    if (r) begin
      chk("log_wdata", log_wdata[i], d);
      chk("log_wmask", log_mask[i], m);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_breq", o_bus_request, 0);
    chk("rst_brw", o_bus_rw, 0);
    chk("rst_baddr", o_bus_address, 0);
    chk("rst_bwdata", o_bus_wdata, 0);
    chk("rst_bwmask", o_bus_wmask, 0);
    rst_n = 1;
    // Three cached writes then an uncached write that must wait for them.
    host(1, 1, 32'hcafe_0001, 32'hb00b_1111, 4'b1010, lat); chk("w1_lat", lat, 1);
    host(1, 1, 32'hcafe_0002, 32'hb00b_2222, 4'b0101, lat); chk("w2_lat", lat, 1);
    host(1, 1, 32'hcafe_0003, 32'hb00b_3333, 4'b1111, lat); chk("w3_lat", lat, 1);
    host(1, 0, 32'hcafe_0004, 32'hb00b_4444, 4'b0011, lat);
    chk("uc_count", nlog, 4);
    chk_log(0, 1, 32'hcafe_0001, 32'hb00b_1111, 4'b1010);
    chk_log(1, 1, 32'hcafe_0002, 32'hb00b_2222, 4'b0101);
    chk_log(2, 1, 32'hcafe_0003, 32'hb00b_3333, 4'b1111);
    chk_log(3, 1, 32'hcafe_0004, 32'hb00b_4444, 4'b0011);
    // Read with swapped-halves return data.
    host(0, 1, 32'hcafe_0003, 32'h0, 4'h0, lat);
    chk("rd1_data", o_rdata, 32'h0003_cafe);
    chk("rd1_count", nlog, 5);
    chk_log(4, 0, 32'hcafe_0003, 0, 0);
    // Four queued writes behind a held bus, then a read that must follow them.
    base = nlog;
    bus_hold = 1;
    for (int i = 0; i < 4; i++) begin
      host(1, 1, 32'hcafe_0005 + i, 32'hb00b_5555 + i, 4'(i + 1), lat);
      chk("q_lat", lat, 1);
    end
    chk("q_full", o_full, 1);
    chk("rdata_hold", o_rdata, 32'h0003_cafe);
    bus_hold = 0;
    host(0, 1, 32'hcafe_0005, 32'h0, 4'h0, lat);
    chk("rd2_data", o_rdata, 32'h0005_cafe);
    chk("rd2_count", nlog, base + 5);
    for (int i = 0; i < 4; i++) chk_log(base + i, 1, 32'hcafe_0005 + i, 32'hb00b_5555 + i, 4'(i + 1));
    chk_log(base + 4, 0, 32'hcafe_0005, 0, 0);
    // Full buffer: fifth write stalls until the first pop.
    wait_empty();
    base = nlog;
    bus_hold = 1;
    for (int i = 0; i < 4; i++) host(1, 1, 32'hcafe_0010 + i, 32'hb00b_0010 + i, 4'hf, lat);
    chk("f_full", o_full, 1);
    @(negedge clk);
    rw = 1; cached = 1; addr = 32'hcafe_0014; wdata = 32'hb00b_0014; wmask = 4'h6; req = 1;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (o_ready) cnt++; end
    chk("f_stall", cnt, 0);
    chk("f_still_full", o_full, 1);
    bus_hold = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!o_ready && lat < 100);
    chk("f_ack", o_ready, 1);
    chk("f_popped", nlog > base, 1);
    req = 0;
    wait_empty();
    chk("f_count", nlog, base + 5);
    for (int i = 0; i < 4; i++) chk_log(base + i, 1, 32'hcafe_0010 + i, 32'hb00b_0010 + i, 4'hf);
    chk_log(base + 4, 1, 32'hcafe_0014, 32'hb00b_0014, 4'h6);
    // A held request is accepted only once.
    base = nlog;
    @(negedge clk);
    rw = 1; cached = 1; addr = 32'hcafe_000a; wdata = 32'hb00b_aaaa; wmask = 4'h9; req = 1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (o_ready) cnt++; end
    req = 0;
    chk("hold_once", cnt, 1);
    wait_empty();
    chk("hold_count", nlog, base + 1);
    // Reset in the middle of a drain.
    base = nlog;
    bus_hold = 1;
    host(1, 1, 32'hcafe_0009, 32'hb00b_9999, 4'hc, lat);
    chk("r_lat", lat, 1);
    chk("r_pre_req", o_bus_request, 1);
    chk("r_pre_empty", o_empty, 0);
    #2 rst_n = 0;
    #1;
    chk("r_req_drop", o_bus_request, 0);
    chk("r_empty", o_empty, 1);
    chk("r_addr", o_bus_address, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    bus_hold = 0;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (o_ready || o_bus_request) cnt++; end
    chk("r_quiet", cnt, 0);
    chk("r_nolog", nlog, base);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
